// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch SRAM bridge.
package ifetch_pkg;

  localparam int unsigned C_WORD_BYTES = 4;
  localparam int unsigned C_DATA_W     = 32;

  typedef struct packed {
    logic                rerr;
    logic [C_DATA_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Power-of-two response FIFO; head is read straight from the storage array.
module imem_rsp_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  rsp_t                   push_data,
  input  logic                   pop,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output rsp_t                   head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rsp_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/imem_sram_bridge.sv
// Bridges a valid/ready instruction fetch port onto a single-cycle-latency SRAM,
// buffering read data in an in-order response FIFO.
module imem_sram_bridge
  import ifetch_pkg::*;
#(
  parameter int unsigned C_ADDR_W    = 10,
  parameter int unsigned C_RSP_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  output logic                treqready_o,
  input  logic                treqvalid_i,
  input  logic [1:0]          treqpriv_i,
  input  logic [31:0]         treqaddr_i,
  input  logic                trspready_i,
  output logic                trspvalid_o,
  output logic                trsprerr_o,
  output logic [31:0]         trspdata_o,
  output logic                sram_ce_o,
  output logic [C_ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]         sram_rdata_i
);

  localparam int unsigned CNT_W = $clog2(C_RSP_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic             inflight_q;
  logic             inflight_err_q;
  logic             legal;
  logic             accept;
  logic             pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0] occupancy;
  logic [OCC_W-1:0] avail_occ;
  rsp_t             push_data;
  rsp_t             head;
  logic             unused_priv;

  // Privilege travels with the request but is never inspected.
  assign unused_priv = ^treqpriv_i;

  assign legal = (treqaddr_i[1:0] == 2'b00) &&
                 ((treqaddr_i >> (C_ADDR_W + 2)) == 32'd0);

  // The in-flight read already owns a FIFO slot, so the push can never overflow.
  assign occupancy   = OCC_W'(fifo_count) + OCC_W'(inflight_q);
  assign avail_occ   = occupancy - OCC_W'(pop);
  assign treqready_o = ~reset_i & (avail_occ < OCC_W'(C_RSP_DEPTH));
  assign accept      = treqvalid_i & treqready_o;

  assign sram_ce_o   = accept & legal;
  assign sram_addr_o = treqaddr_i[C_ADDR_W+1:2];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
    end else begin
      inflight_q     <= accept;
      inflight_err_q <= accept & ~legal;
    end
  end

  assign push_data.rerr = inflight_err_q;
  assign push_data.data = inflight_err_q ? 32'd0 : sram_rdata_i;

  imem_rsp_fifo #(
    .DEPTH(C_RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk_i),
    .rst      (reset_i),
    .push     (inflight_q),
    .push_data(push_data),
    .pop      (pop),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (head)
  );

  // Response outputs are forced quiet while reset is held.
  assign trspvalid_o = ~reset_i & ~fifo_empty;
  assign trsprerr_o  = ~reset_i & head.rerr;
  assign trspdata_o  = reset_i ? 32'd0 : head.data;
  assign pop         = trspvalid_o & trspready_i;

endmodule

// File: tb/tb_imem_sram_bridge.sv
// Scoreboard bench for imem_sram_bridge: directed scenarios plus a random-stall run.
module tb_imem_sram_bridge;
  import ifetch_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          treqready_o;
  logic          treqvalid_i;
  logic [1:0]    treqpriv_i;
  logic [31:0]   treqaddr_i;
  logic          trspready_i;
  logic          trspvalid_o;
  logic          trsprerr_o;
  logic [31:0]   trspdata_o;
  logic          sram_ce_o;
  logic [AW-1:0] sram_addr_o;
  logic [31:0]   sram_rdata_i;

  logic [31:0] mem [1024];
  rsp_t        expq[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  bit          rand_mode = 1'b0;

  imem_sram_bridge #(.C_ADDR_W(AW), .C_RSP_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .treqready_o (treqready_o),
    .treqvalid_i (treqvalid_i),
    .treqpriv_i  (treqpriv_i),
    .treqaddr_i  (treqaddr_i),
    .trspready_i (trspready_i),
    .trspvalid_o (trspvalid_o),
    .trsprerr_o  (trsprerr_o),
    .trspdata_o  (trspdata_o),
    .sram_ce_o   (sram_ce_o),
    .sram_addr_o (sram_addr_o),
    .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk = ~clk;

  // SRAM model: data one cycle after ce, garbage otherwise.
  always @(posedge clk) sram_rdata_i <= sram_ce_o ? mem[sram_addr_o] : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:12] == 20'd0);
  endfunction

  function automatic rsp_t exp_rsp(input logic [31:0] a);
    rsp_t r;
    if (is_legal(a)) begin
      r.rerr = 1'b0;
      r.data = mem[a[11:2]];
    end else begin
      r.rerr = 1'b1;
      r.data = 32'd0;
    end
    return r;
  endfunction

  // Monitor compares first, then the request observer pushes expectations.
  always @(negedge clk) begin
    if (reset_i) begin
      chk("rst_valid", 64'(trspvalid_o), 64'd0);
      chk("rst_rerr",  64'(trsprerr_o),  64'd0);
      chk("rst_data",  64'(trspdata_o),  64'd0);
      chk("rst_ce",    64'(sram_ce_o),   64'd0);
      chk("rst_ready", 64'(treqready_o), 64'd0);
      expq.delete();
    end else begin
      if (trspvalid_o) begin
        if (expq.size() == 0) begin
          chk("spurious_rsp", 64'(trspvalid_o), 64'd0);
        end else begin
          chk("rsp_rerr", 64'(trsprerr_o), 64'(expq[0].rerr));
          chk("rsp_data", 64'(trspdata_o), 64'(expq[0].data));
          if (trspready_i) void'(expq.pop_front());
        end
      end
      if (treqvalid_i && treqready_o) begin
        expq.push_back(exp_rsp(treqaddr_i));
        chk("sram_ce", 64'(sram_ce_o), 64'(is_legal(treqaddr_i)));
        if (is_legal(treqaddr_i)) chk("sram_addr", 64'(sram_addr_o), 64'(treqaddr_i[11:2]));
      end else begin
        chk("sram_ce_idle", 64'(sram_ce_o), 64'd0);
      end
    end
  end

  // Present a request until accepted; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input bit must_ready);
    int t = 0;
    treqvalid_i = 1'b1;
    treqaddr_i  = a;
    @(negedge clk);
    if (must_ready) chk("req_ready", 64'(treqready_o), 64'd1);
    while (!treqready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("req_timeout", 64'(t), 64'd0);
    @(posedge clk);
    #1;
    treqvalid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 ^ 32'(i * 7919);
    mem[3] = 32'h00000013;
    reset_i = 1'b1; treqvalid_i = 1'b0; treqaddr_i = '0; treqpriv_i = '0; trspready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;

    // Single read right after reset, with exact latency.
    issue(32'h0000000C, 1'b1);
    @(negedge clk); chk("lat_n1_valid", 64'(trspvalid_o), 64'd0);
    @(negedge clk); chk("lat_n2_valid", 64'(trspvalid_o), 64'd1);
    chk("lat_n2_data", 64'(trspdata_o), 64'h13);
    chk("lat_n2_rerr", 64'(trsprerr_o), 64'd0);
    idle(3);

    // Back-to-back at full rate.
    issue(32'h0, 1'b1); issue(32'h4, 1'b1); issue(32'h8, 1'b1);
    @(negedge clk); chk("b2b_valid_1", 64'(trspvalid_o), 64'd1);
    @(negedge clk); chk("b2b_valid_2", 64'(trspvalid_o), 64'd1);
    @(negedge clk); chk("b2b_valid_3", 64'(trspvalid_o), 64'd0);
    idle(2);

    // Backpressure: full FIFO blocks requests, one pop frees a slot.
    trspready_i = 1'b0;
    issue(32'h10, 1'b1); issue(32'h14, 1'b1);
    treqvalid_i = 1'b1; treqaddr_i = 32'h18;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", 64'(treqready_o), 64'd0);
      chk("bp_valid", 64'(trspvalid_o), 64'd1);
    end
    @(posedge clk); #1 trspready_i = 1'b1;
    @(negedge clk); chk("bp_release_ready", 64'(treqready_o), 64'd1);
    @(posedge clk); #1 trspready_i = 1'b0; treqvalid_i = 1'b0;
    @(negedge clk); chk("bp_after_pop_valid", 64'(trspvalid_o), 64'd1);
    @(posedge clk); #1 trspready_i = 1'b1;
    idle(6);

    // Error responses interleaved with legal ones.
    issue(32'h00000002, 1'b0); issue(32'h00000008, 1'b0);
    issue(32'h00001000, 1'b0); issue(32'h00000FFC, 1'b0);
    idle(6);

    // Reset mid-stream with two responses buffered.
    trspready_i = 1'b0;
    issue(32'h20, 1'b0); issue(32'h24, 1'b0);
    idle(2);
    reset_i = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0; trspready_i = 1'b1;
    @(negedge clk); chk("post_rst_ready", 64'(treqready_o), 64'd1);
    repeat (5) begin
      chk("post_rst_valid", 64'(trspvalid_o), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Random requests against random response stalls.
    rand_mode = 1'b1;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          logic [31:0] a;
          int r;
          r = $urandom_range(0, 15);
          a = {20'd0, 10'($urandom), 2'b00};
          if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
          else if (r == 1) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
          treqpriv_i = 2'($urandom);
          issue(a, 1'b0);
          if ($urandom_range(0, 7) == 0) idle(1);
        end
        rand_mode = 1'b0;
      end
      begin
        while (rand_mode) begin
          trspready_i = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join

    trspready_i = 1'b1;
    t = 0;
    while (expq.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_pending", 64'(expq.size()), 64'd0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
